ped_button_station: RTL
=======================

Name: ped_button_station

Overview:
Pedestrian-side push-button and signal-head unit; the request end of the crossing controller's button/lamp interface. It debounces the raw push-button and holds a level request (btn_req) to the crossing controller until the controller acknowledges it. It then watches the controller's lamp and walk status lines to drive a "wait" indicator and an accessible audio tick pattern, and flags illegal status combinations. All timing is in clock cycles; the system clock is the same 100 Hz tick (10 ms period) as the controller.

Parameters:
DEBOUNCE_CYCLES, 5, consecutive stable synced samples needed to change debounced button level
WALK_TICK_PERIOD, 10, speaker pattern period while walk=1
WALK_TICK_ON, 5, speaker high cycles per period while walk=1
LOCATOR_PERIOD, 100, speaker pattern period while walk=0
LOCATOR_ON, 5, speaker high cycles per period while walk=0
REQ_TIMEOUT, 3000, max cycles in ASSERT without seeing yellow before fault

Ports:
clock  input  1  system clock, 100 Hz tick
reset_n  input  1  reset, asynchronous, active-low
btn_raw  input  1  raw push-button, asynchronous, bouncy
green  input  1  controller green lamp status, same clock domain
yellow  input  1  controller yellow lamp status
red  input  1  controller red lamp status
walk  input  1  controller walk status
no_walk  input  1  controller don't-walk status
btn_req  output  1  level request to the controller's button input
wait_lamp  output  1  "request registered" indicator
speaker  output  1  audio tick drive
req_count  output  8  saturating count of acknowledged requests
fault  output  1  sticky protocol fault

Behaviour:
- Reset (reset_n=0, async): all outputs 0; FSM=IDLE; sync flops, debounced level, debounce counter, phase counter, walk_q, timeout counter all 0.
- Input conditioning: btn_raw passes through a 2-flop synchronizer. The debounced level db takes the synced value once it has differed from db for DEBOUNCE_CYCLES consecutive cycles; any mismatch gap restarts the count. press = rising edge of db (1-cycle pulse).
- Status inputs share the controller's clock and are used unsynchronized.
- Request FSM (registered; outputs are decoded from state):
  - IDLE (btn_req=0, wait_lamp=0): press & green -> ASSERT; press & !green -> ARM.
  - ARM (btn_req=0, wait_lamp=1): green -> ASSERT.
  - ASSERT (btn_req=1, wait_lamp=1): yellow -> SERVED, req_count+1 (saturating at 255). Timeout counter reaches REQ_TIMEOUT -> fault=1, IDLE.
  - SERVED (btn_req=0, wait_lamp=0): presses ignored; falling edge of walk (walk_q=1, walk=0) -> IDLE.
  - Timeout counter clears on ASSERT entry and counts only in ASSERT.
- Latency: green sampled in ARM gives btn_req=1 the following cycle. Yellow sampled in ASSERT gives btn_req=0 the following cycle.
- Press and state-exit condition in the same cycle: the exit wins, and the press is dropped.
- Fault detection: fault is set the cycle after any of:
  - walk & green
  - walk & no_walk
  - two or more of red/yellow/green high together
  - request timeout
- Fault handling: fault is sticky until reset. While fault=1 the FSM is forced to IDLE and stays there, and btn_req=0 and wait_lamp=0. req_count holds its value.
- Audio:
  - walk_q is a register of walk. Phase counter p: if walk != walk_q then p <= 0; else p <= (p == PERIOD-1) ? 0 : p+1.
  - PERIOD/ON are selected by walk_q (WALK_* if 1, else LOCATOR_*). speaker = (p < ON).
  - Walk edge: speaker is high 1 cycle after walk changes, and the pattern restarts at phase 0.
  - Fault does not mute the speaker.
- Widths: p and timeout counter are sized to clog2 of their maximum parameter value.

Test Plan:
1. Debounce: btn_raw 3-cycle glitch with green=1 -> FSM stays IDLE, btn_req=0. btn_raw held high 20 cycles -> btn_req=1 and wait_lamp=1 within 2+5+2 cycles of the rising edge.
2. Handshake: in ASSERT, drive green=0, yellow=1 -> next cycle btn_req=0, wait_lamp=0, req_count=1. Walk high 1200 cycles then low -> IDLE. Repeat 300 times -> req_count=255.
3. Deferred request: press while red=1, green=0 -> ARM (btn_req=0, wait_lamp=1). Raise green=1 -> btn_req=1 next cycle.
4. Audio: after reset, walk=0 -> speaker high cycles 0-4 of every 100. Walk rises -> speaker high the next cycle, then 5 on/5 off. Walk falls -> locator pattern restarts at phase 0.
5. Timeout: hold green=1, yellow=0 in ASSERT for 3000 cycles -> fault=1, btn_req=0. Later presses leave btn_req=0.
6. Illegal status: walk=1 & green=1 -> fault=1 next cycle. Separately, reset_n low mid-ASSERT -> btn_req, wait_lamp, fault, req_count all 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ped_button_station.sv
// Pedestrian push-button station: debounced request handshake, wait lamp, audio ticks, sticky fault.
// Button-to-request latency is 8 cycles. Status lines are level inputs, so there is no backpressure.
module ped_button_station #(
   parameter int DEBOUNCE_CYCLES  = 5,
   parameter int WALK_TICK_PERIOD = 10,
   parameter int WALK_TICK_ON     = 5,
   parameter int LOCATOR_PERIOD   = 100,
   parameter int LOCATOR_ON       = 5,
   parameter int REQ_TIMEOUT      = 3000
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       btn_raw,
   input  logic       green,
   input  logic       yellow,
   input  logic       red,
   input  logic       walk,
   input  logic       no_walk,
   output logic       btn_req,
   output logic       wait_lamp,
   output logic       speaker,
   output logic [7:0] req_count,
   output logic       fault
);

   localparam int PMAX = (WALK_TICK_PERIOD > LOCATOR_PERIOD) ? WALK_TICK_PERIOD : LOCATOR_PERIOD;
   localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int PW   = $clog2(PMAX);
   localparam int TW   = $clog2(REQ_TIMEOUT);

   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [PW-1:0] WALK_LAST = PW'(WALK_TICK_PERIOD - 1);
   localparam logic [PW-1:0] LOC_LAST  = PW'(LOCATOR_PERIOD - 1);
   localparam logic [PW-1:0] WALK_ON   = PW'(WALK_TICK_ON);
   localparam logic [PW-1:0] LOC_ON    = PW'(LOCATOR_ON);
   localparam logic [TW-1:0] T_LAST    = TW'(REQ_TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_ASSERT, S_SERVED} state_t;

   state_t        state;
   logic          sync1, sync2, db, db_q;
   logic [DW-1:0] db_cnt;
   logic [TW-1:0] tcnt;
   logic [PW-1:0] p, p_nxt;
   logic          walk_q;
   logic          press, illegal, timeout_hit, fault_nxt, spk_nxt;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         db     <= 1'b0;
         db_q   <= 1'b0;
         db_cnt <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
         db_q  <= db;
         // Any cycle that agrees with db restarts the stability count.
         if (sync2 == db) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            db     <= sync2;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   assign press       = db & ~db_q;
   assign illegal     = (walk & green) | (walk & no_walk) |
                        (red & yellow) | (red & green) | (yellow & green);
   assign timeout_hit = (state == S_ASSERT) && !yellow && (tcnt == T_LAST);
   assign fault_nxt   = fault | illegal | timeout_hit;

   // A fault overrides every transition, so the request drops on the same edge the fault rises.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         tcnt      <= '0;
         req_count <= 8'd0;
         fault     <= 1'b0;
         btn_req   <= 1'b0;
         wait_lamp <= 1'b0;
      end else begin
         fault <= fault_nxt;
         if (fault_nxt) begin
            state     <= S_IDLE;
            btn_req   <= 1'b0;
            wait_lamp <= 1'b0;
         end else begin
            case (state)
               S_IDLE: if (press) begin
                  state     <= green ? S_ASSERT : S_ARM;
                  btn_req   <= green;
                  wait_lamp <= 1'b1;
                  tcnt      <= '0;
               end
               S_ARM: if (green) begin
                  state   <= S_ASSERT;
                  btn_req <= 1'b1;
                  tcnt    <= '0;
               end
               S_ASSERT: if (yellow) begin
                  state     <= S_SERVED;
                  btn_req   <= 1'b0;
                  wait_lamp <= 1'b0;
                  if (req_count != 8'hFF) req_count <= req_count + 1'b1;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
               S_SERVED: if (walk_q && !walk) state <= S_IDLE;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   // Pattern phase restarts on either walk edge; the period follows the settled walk level.
   always_comb begin
      p_nxt = '0;
      if (walk == walk_q) p_nxt = (p == (walk_q ? WALK_LAST : LOC_LAST)) ? '0 : p + 1'b1;
   end

   assign spk_nxt = p_nxt < (walk ? WALK_ON : LOC_ON);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         p       <= '0;
         walk_q  <= 1'b0;
         speaker <= 1'b0;
      end else begin
         p       <= p_nxt;
         walk_q  <= walk;
         speaker <= spk_nxt;
      end
   end

endmodule
